// File: rtl/edge2en_multi.sv
// edge2en_multi: multi-channel edge-to-enable converter.
// Per channel: synchroniser, stable-count glitch filter, one-cycle rising and
// falling pulses, and a sticky mode-selected event flag with clear.
// irq_out is the OR of all event flags.
module edge2en_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [CH-1:0]   edge_in,
  input  logic [2*CH-1:0] mode_in,
  input  logic [CH-1:0]   clr_in,
  output logic [CH-1:0]   level_out,
  output logic [CH-1:0]   rising_out,
  output logic [CH-1:0]   falling_out,
  output logic [CH-1:0]   event_out,
  output logic            irq_out
);

  localparam int            CW      = $clog2(FILT_CYC) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC - 1);

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0]                  level_q, level_d;
  logic [CH-1:0]                  level_dly_q, level_dly_d;
  logic [CH-1:0]                  event_q, event_d;
  logic [CH-1:0]                  sync_s;

  // Last synchroniser stage is the only point the filter may look at.
  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift each channel's raw input down its synchroniser chain.
  always_comb begin
    // NOTE: every always_comb target gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    sync_d    = sync_q;
    sync_d[0] = edge_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Glitch filter: a new level must persist FILT_CYC consecutive cycles;
  // any return to the current level discards the partial count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      if (sync_s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = sync_s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // One-cycle-delayed copy of the filtered level for edge detection.
  always_comb begin
    level_dly_d = level_q;
  end

  // Sticky event flag: an enabled edge sets it and wins over a same-cycle clear.
  always_comb begin
    event_d = event_q;
    for (int i = 0; i < CH; i++) begin
      if ((mode_in[2*i] & rising_out[i]) | (mode_in[2*i+1] & falling_out[i])) begin
        event_d[i] = 1'b1;
      end else if (clr_in[i]) begin
        event_d[i] = 1'b0;
      end
    end
  end

  // State registers. Release of rst_in is expected to be synchronous to
  // clk_in already (handled by the upstream reset generator).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: the synchroniser chain is reset too, so no stale pre-reset
      // level can leak into the filter after release.
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      event_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      event_q     <= event_d;
    end
  end

  // Outputs are decoded from flops only; pulses are not gated by mode_in.
  assign level_out   = level_q;
  assign rising_out  = level_q & ~level_dly_q;
  assign falling_out = ~level_q & level_dly_q;
  assign event_out   = event_q;
  assign irq_out     = |event_q;

endmodule

// File: tb/tb_edge2en_multi.sv
// Directed bench for edge2en_multi with CH=4, SYNC_STAGES=2, FILT_CYC=4.
// Inputs change 1 time unit after a rising edge; the following rising edge
// is "edge 1" for latency counting. Outputs are sampled 1 unit after edges.
module tb_edge2en_multi;

  logic       clk;
  logic       rst;
  logic [3:0] edge_in;
  logic [7:0] mode_in;
  logic [3:0] clr_in;
  logic [3:0] level_out;
  logic [3:0] rising_out;
  logic [3:0] falling_out;
  logic [3:0] event_out;
  logic       irq_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0] seen_pulse;
  logic [3:0] seen_rise;
  logic [3:0] seen_fall;
  logic [3:0] seen_event;
  logic [3:0] seen_level_low;

  edge2en_multi #(.CH(4), .SYNC_STAGES(2), .FILT_CYC(4)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .edge_in     (edge_in),
    .mode_in     (mode_in),
    .clr_in      (clr_in),
    .level_out   (level_out),
    .rising_out  (rising_out),
    .falling_out (falling_out),
    .event_out   (event_out),
    .irq_out     (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},   32'(level_out),   32'h0);
    check({tag, "_rising"},  32'(rising_out),  32'h0);
    check({tag, "_falling"}, 32'(falling_out), 32'h0);
    check({tag, "_event"},   32'(event_out),   32'h0);
    check({tag, "_irq"},     32'(irq_out),     32'h0);
  endtask

  initial begin
    rst     = 1'b1;
    edge_in = 4'h0;
    mode_in = 8'h00;
    clr_in  = 4'h0;
    repeat (3) step();
    check_all_zero("in_reset");
    rst = 1'b0;
    step();
    check_all_zero("after_reset");

    // 1: ch0 mode rising, ch1 mode both; ch0 goes high and stays high.
    mode_in    = 8'b00_00_11_01;
    edge_in[0] = 1'b1;
    repeat (5) step();
    check("t1_edge5_level", 32'(level_out), 32'h0);
    check("t1_edge5_rising", 32'(rising_out), 32'h0);
    step();
    check("t1_edge6_rising", 32'(rising_out), 32'h1);
    check("t1_edge6_level", 32'(level_out), 32'h1);
    check("t1_edge6_event", 32'(event_out), 32'h0);
    step();
    check("t1_edge7_rising", 32'(rising_out), 32'h0);
    check("t1_edge7_event", 32'(event_out), 32'h1);
    check("t1_edge7_irq", 32'(irq_out), 32'h1);
    clr_in = 4'hf;
    step();
    clr_in = 4'h0;
    check("t1_clear_event", 32'(event_out), 32'h0);

    // 2: ch1 glitch of 3 cycles is filtered out entirely.
    edge_in[1] = 1'b1;
    repeat (3) step();
    edge_in[1] = 1'b0;
    seen_pulse = 4'h0;
    seen_event = 4'h0;
    seen_level_low = 4'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_pulse     |= rising_out | falling_out;
      seen_event     |= event_out;
      seen_level_low |= level_out;
    end
    check("t2_glitch_pulses", 32'(seen_pulse), 32'h0);
    check("t2_glitch_event", 32'(seen_event), 32'h0);
    check("t2_glitch_level", 32'(seen_level_low), 32'h1);
    // 4-cycle pulse passes: rising at edge 6, falling 4 cycles later.
    edge_in[1] = 1'b1;
    repeat (4) step();
    edge_in[1] = 1'b0;
    step();
    check("t2_edge5_rising", 32'(rising_out), 32'h0);
    step();
    check("t2_edge6_rising", 32'(rising_out), 32'h2);
    check("t2_edge6_level", 32'(level_out), 32'h3);
    step();
    check("t2_edge7_rising", 32'(rising_out), 32'h0);
    check("t2_edge7_event", 32'(event_out), 32'h2);
    step();
    check("t2_edge8_falling", 32'(falling_out), 32'h0);
    step();
    check("t2_edge9_falling", 32'(falling_out), 32'h0);
    step();
    check("t2_edge10_falling", 32'(falling_out), 32'h2);
    check("t2_edge10_level", 32'(level_out), 32'h1);
    step();
    check("t2_edge11_falling", 32'(falling_out), 32'h0);
    clr_in = 4'hf;
    step();
    clr_in = 4'h0;
    check("t2_clear_irq", 32'(irq_out), 32'h0);

    // 3: ch2 mode falling: no event on rise, event after fall.
    mode_in    = 8'b00_10_11_01;
    edge_in[2] = 1'b1;
    repeat (6) step();
    check("t3_rising", 32'(rising_out), 32'h4);
    edge_in[2] = 1'b0;
    step();
    check("t3_no_event_on_rise", 32'(event_out), 32'h0);
    repeat (5) step();
    check("t3_falling", 32'(falling_out), 32'h4);
    check("t3_event_not_yet", 32'(event_out), 32'h0);
    step();
    check("t3_event_after_fall", 32'(event_out), 32'h4);
    check("t3_irq", 32'(irq_out), 32'h1);
    clr_in[2] = 1'b1;
    step();
    clr_in[2] = 1'b0;
    check("t3_clear_event", 32'(event_out), 32'h0);
    // Mode off: pulses still produced, flag never set.
    mode_in    = 8'b00_00_11_01;
    seen_rise  = 4'h0;
    seen_fall  = 4'h0;
    seen_event = 4'h0;
    edge_in[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_rise |= rising_out; seen_fall |= falling_out; seen_event |= event_out;
    end
    edge_in[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen_rise |= rising_out; seen_fall |= falling_out; seen_event |= event_out;
    end
    check("t3_off_rise", 32'(seen_rise), 32'h4);
    check("t3_off_fall", 32'(seen_fall), 32'h4);
    check("t3_off_event", 32'(seen_event), 32'h0);

    // 4: set wins over simultaneous clear; clear alone then takes effect.
    edge_in[0] = 1'b0;
    repeat (7) step();
    check("t4_fall_no_event", 32'(event_out), 32'h0);
    check("t4_level_low", 32'(level_out), 32'h0);
    edge_in[0] = 1'b1;
    repeat (6) step();
    check("t4_rising", 32'(rising_out), 32'h1);
    clr_in[0] = 1'b1;
    step();
    check("t4_set_wins", 32'(event_out), 32'h1);
    check("t4_set_wins_irq", 32'(irq_out), 32'h1);
    step();
    clr_in[0] = 1'b0;
    check("t4_clear_alone", 32'(event_out), 32'h0);
    check("t4_clear_irq", 32'(irq_out), 32'h0);

    // 5: reset mid-count on ch3 clears everything at once; power-up high
    //    inputs (ch0 and ch3) report a rising edge at edge 6 after release.
    mode_in    = 8'b01_00_11_01;
    edge_in[3] = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check_all_zero("t5_async_reset");
    repeat (2) step();
    check("t5_held_level", 32'(level_out), 32'h0);
    rst = 1'b0;
    repeat (5) step();
    check("t5_edge5_rising", 32'(rising_out), 32'h0);
    check("t5_edge5_level", 32'(level_out), 32'h0);
    step();
    check("t5_edge6_rising", 32'(rising_out), 32'h9);
    check("t5_edge6_level", 32'(level_out), 32'h9);
    step();
    check("t5_edge7_event", 32'(event_out), 32'h9);
    clr_in = 4'hf;
    step();
    clr_in = 4'h0;
    check("t5_clear", 32'(event_out), 32'h0);

    // 6: ch0 toggling every cycle never passes the filter.
    mode_in        = 8'b01_00_11_11;
    seen_pulse     = 4'h0;
    seen_event     = 4'h0;
    seen_level_low = 4'h0;
    for (int i = 0; i < 26; i++) begin
      if (i < 20) edge_in[0] = ~edge_in[0];
      step();
      seen_pulse     |= rising_out | falling_out;
      seen_event     |= event_out;
      seen_level_low |= ~level_out;
    end
    check("t6_toggle_pulses", 32'(seen_pulse), 32'h0);
    check("t6_toggle_event", 32'(seen_event), 32'h0);
    check("t6_toggle_level_low", 32'(seen_level_low), 32'h6);
    check("t6_final_level", 32'(level_out), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
